// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace-control register block.
package trdb_pkg;

    typedef enum logic [1:0] {
        FULL_ADDRESS  = 2'd0,
        DELTA_ADDRESS = 2'd1
    } ioptions_e;

    typedef enum logic [1:0] {
        CH_OFF   = 2'd0,
        CH_ON    = 2'd1,
        CH_STALL = 2'd2
    } trdb_ch_state_e;

    localparam int unsigned TRDB_REG_CTRL   = 0;
    localparam int unsigned TRDB_REG_CH_EN  = 1;
    localparam int unsigned TRDB_REG_STATUS = 2;
    localparam int unsigned TRDB_REG_SW_REQ = 3;

    localparam int unsigned CTRL_ACTIVATED     = 0;
    localparam int unsigned CTRL_NOCONTEXT     = 1;
    localparam int unsigned CTRL_NOTIME        = 2;
    localparam int unsigned CTRL_DELTA_ADDRESS = 3;

endpackage

// File: rtl/pulp_clock_gating.sv
// Latch-based clock gate: enable is captured while the clock is low.
module pulp_clock_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic en_latch;

    always_latch begin
        if (!clk_i) begin
            en_latch = en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/trdb_trace_ch_fsm.sv
// One trace channel: request edge detectors, OFF/ON/STALL FSM and stall counter.
// Macro TRDB_REG_STALL_TIMEOUT_EN enables the STALL state; otherwise backpressure drops at once.
module trdb_trace_ch_fsm
    import trdb_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_on,
    input  logic req_off,
    input  logic sw_on,
    input  logic sw_off,
    input  logic activated,
    input  logic ch_en,
    input  logic ready,
    output logic enable,
    output logic timeout
);

    logic           on_q;
    logic           off_q;
    logic           on_evt;
    logic           off_evt;
    logic           drop;
    trdb_ch_state_e state;
    trdb_ch_state_e state_next;

    assign on_evt  = (req_on & ~on_q) | sw_on;
    assign off_evt = (req_off & ~off_q) | sw_off;
    assign drop    = off_evt | ~activated | ~ch_en;

`ifdef TRDB_REG_STALL_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT);
    // Expire on the cycle the counter would step to STALL_TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_TIMEOUT - 2);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             expired;

    assign expired = (state == CH_STALL) && !ready && (cnt == CNT_LAST);
    assign timeout = expired & ~drop;

    always_comb begin
        cnt_next = '0;
        if (state == CH_STALL && state_next == CH_STALL) begin
            cnt_next = (&cnt) ? cnt : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end
`else
    logic unused_timeout_param;

    assign unused_timeout_param = ^32'(STALL_TIMEOUT);
    assign timeout              = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            CH_OFF: begin
                if (on_evt && activated && ch_en && !off_evt) begin
                    state_next = CH_ON;
                end
            end
            CH_ON: begin
                if (drop) begin
                    state_next = CH_OFF;
                end else if (!ready) begin
`ifdef TRDB_REG_STALL_TIMEOUT_EN
                    state_next = CH_STALL;
`else
                    state_next = CH_OFF;
`endif
                end
            end
`ifdef TRDB_REG_STALL_TIMEOUT_EN
            CH_STALL: begin
                if (drop || expired) begin
                    state_next = CH_OFF;
                end else if (ready) begin
                    state_next = CH_ON;
                end
            end
`endif
            default: state_next = CH_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_q  <= 1'b0;
            off_q <= 1'b0;
            state <= CH_OFF;
        end else begin
            on_q  <= req_on;
            off_q <= req_off;
            state <= state_next;
        end
    end

    assign enable = (state != CH_OFF);

endmodule

// File: rtl/trdb_reg_mc.sv
// Multi-channel trace-control register file with per-channel trace-enable FSMs.
// Macro TRDB_REG_STALL_TIMEOUT_EN enables stall tolerance and the sticky STATUS[15:8] flags.
module trdb_reg_mc
    import trdb_pkg::*;
#(
    parameter int unsigned NR_CHANNELS   = 2,
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned STALL_TIMEOUT = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   reg_req_i,
    input  logic                   reg_we_i,
    input  logic [ADDR_W-1:0]      reg_addr_i,
    input  logic [31:0]            reg_wdata_i,
    output logic [31:0]            reg_rdata_o,
    output logic                   reg_rvalid_o,
    input  logic [NR_CHANNELS-1:0] trace_req_on_i,
    input  logic [NR_CHANNELS-1:0] trace_req_off_i,
    input  logic                   encapsulator_ready_i,
    output logic [NR_CHANNELS-1:0] trace_enable_o,
    output logic                   trace_activated_o,
    output logic                   nocontext_o,
    output logic                   notime_o,
    output logic                   delta_address_o,
    output logic                   encoder_mode_o,
    output ioptions_e              configuration_o,
    output logic                   clk_gated_o
);

    logic [3:0]             ctrl;
    logic [NR_CHANNELS-1:0] ch_en;
    logic [NR_CHANNELS-1:0] sw_on;
    logic [NR_CHANNELS-1:0] sw_off;
    logic [NR_CHANNELS-1:0] ch_timeout;
    logic [31:0]            rdata_next;
    logic                   wr;
    logic                   rd;
    logic                   sel_ctrl;
    logic                   sel_chen;
    logic                   sel_status;
    logic                   sel_swreq;
    logic                   unused_wdata;

    assign wr         = reg_req_i & reg_we_i;
    assign rd         = reg_req_i & ~reg_we_i;
    assign sel_ctrl   = (reg_addr_i == ADDR_W'(TRDB_REG_CTRL));
    assign sel_chen   = (reg_addr_i == ADDR_W'(TRDB_REG_CH_EN));
    assign sel_status = (reg_addr_i == ADDR_W'(TRDB_REG_STATUS));
    assign sel_swreq  = (reg_addr_i == ADDR_W'(TRDB_REG_SW_REQ));

    assign unused_wdata = ^reg_wdata_i;

    // SW_REQ pulses act in the write cycle, like a hardware edge.
    assign sw_on  = (wr && sel_swreq) ? reg_wdata_i[NR_CHANNELS-1:0] : '0;
    assign sw_off = (wr && sel_swreq) ? reg_wdata_i[8 +: NR_CHANNELS] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl  <= 4'b1111;
            ch_en <= '1;
        end else begin
            if (wr && sel_ctrl) begin
                ctrl <= reg_wdata_i[3:0];
            end
            if (wr && sel_chen) begin
                ch_en <= reg_wdata_i[NR_CHANNELS-1:0];
            end
        end
    end

`ifdef TRDB_REG_STALL_TIMEOUT_EN
    logic [7:0] stall_flags;
    logic [7:0] flags_next;

    // A timeout set in the same cycle as a w1c clear wins.
    always_comb begin
        flags_next = stall_flags;
        if (wr && sel_status) begin
            flags_next = flags_next & ~reg_wdata_i[15:8];
        end
        flags_next = flags_next | 8'(ch_timeout);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_flags <= '0;
        end else begin
            stall_flags <= flags_next;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^ch_timeout;
`endif

    always_comb begin
        rdata_next = '0;
        if (sel_ctrl) begin
            rdata_next[3:0] = ctrl;
        end else if (sel_chen) begin
            rdata_next[NR_CHANNELS-1:0] = ch_en;
        end else if (sel_status) begin
            rdata_next[NR_CHANNELS-1:0] = trace_enable_o;
`ifdef TRDB_REG_STALL_TIMEOUT_EN
            rdata_next[15:8] = stall_flags;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_rdata_o  <= '0;
            reg_rvalid_o <= 1'b0;
        end else begin
            reg_rvalid_o <= rd;
            if (rd) begin
                reg_rdata_o <= rdata_next;
            end
        end
    end

    for (genvar c = 0; c < NR_CHANNELS; c++) begin : g_ch
        trdb_trace_ch_fsm #(
            .STALL_TIMEOUT(STALL_TIMEOUT)
        ) u_fsm (
            .clk      (clk_i),
            .rst      (rst_i),
            .req_on   (trace_req_on_i[c]),
            .req_off  (trace_req_off_i[c]),
            .sw_on    (sw_on[c]),
            .sw_off   (sw_off[c]),
            .activated(ctrl[CTRL_ACTIVATED]),
            .ch_en    (ch_en[c]),
            .ready    (encapsulator_ready_i),
            .enable   (trace_enable_o[c]),
            .timeout  (ch_timeout[c])
        );
    end

    assign trace_activated_o = ctrl[CTRL_ACTIVATED];
    assign nocontext_o       = ctrl[CTRL_NOCONTEXT];
    assign notime_o          = ctrl[CTRL_NOTIME];
    assign delta_address_o   = ctrl[CTRL_DELTA_ADDRESS];
    assign encoder_mode_o    = 1'b0;
    assign configuration_o   = ctrl[CTRL_DELTA_ADDRESS] ? DELTA_ADDRESS : FULL_ADDRESS;

    pulp_clock_gating u_clk_gate (
        .clk_i    (clk_i),
        .en_i     (trace_activated_o),
        .test_en_i(1'b0),
        .clk_o    (clk_gated_o)
    );

endmodule

// File: tb/tb_trdb_reg_mc.sv
// Self-checking bench for trdb_reg_mc: register table plus hand-written channel sequences.
module tb_trdb_reg_mc;
    import trdb_pkg::*;

    localparam int unsigned NCH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            reg_req;
    logic            reg_we;
    logic [3:0]      reg_addr;
    logic [31:0]     reg_wdata;
    logic [31:0]     reg_rdata;
    logic            reg_rvalid;
    logic [NCH-1:0]  req_on;
    logic [NCH-1:0]  req_off;
    logic            ready;
    logic [NCH-1:0]  enable;
    logic            activated;
    logic            nocontext;
    logic            notime;
    logic            delta_address;
    logic            encoder_mode;
    ioptions_e       configuration;
    logic            clk_gated;

    always #5 clk = ~clk;

    trdb_reg_mc #(
        .NR_CHANNELS  (NCH),
        .ADDR_W       (4),
        .STALL_TIMEOUT(16)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .reg_req_i           (reg_req),
        .reg_we_i            (reg_we),
        .reg_addr_i          (reg_addr),
        .reg_wdata_i         (reg_wdata),
        .reg_rdata_o         (reg_rdata),
        .reg_rvalid_o        (reg_rvalid),
        .trace_req_on_i      (req_on),
        .trace_req_off_i     (req_off),
        .encapsulator_ready_i(ready),
        .trace_enable_o      (enable),
        .trace_activated_o   (activated),
        .nocontext_o         (nocontext),
        .notime_o            (notime),
        .delta_address_o     (delta_address),
        .encoder_mode_o      (encoder_mode),
        .configuration_o     (configuration),
        .clk_gated_o         (clk_gated)
    );

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    vec_t        vt[16];
    int          nv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read expectations go on the scoreboard at issue and are popped when rvalid shows.
    task automatic reg_op(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp, input string name);
        logic [31:0] e;
        reg_req   = 1'b1;
        reg_we    = we;
        reg_addr  = addr;
        reg_wdata = wdata;
        if (!we) sb.push_back(exp);
        step();
        reg_req = 1'b0;
        reg_we  = 1'b0;
        if (reg_rvalid) begin
            if (sb.size() == 0) begin
                chk({name, "_spurious_rvalid"}, 32'(reg_rvalid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk(name, reg_rdata, e);
            end
        end else if (!we) begin
            chk({name, "_rvalid"}, 32'(reg_rvalid), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        reg_req   = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        req_on    = '0;
        req_off   = '0;
        ready     = 1'b1;

        vt[0]  = '{1'b0, 4'd0, 32'h0,         32'h0000_000F};
        vt[1]  = '{1'b0, 4'd1, 32'h0,         32'h0000_0003};
        vt[2]  = '{1'b0, 4'd2, 32'h0,         32'h0000_0000};
        vt[3]  = '{1'b0, 4'd3, 32'h0,         32'h0000_0000};
        vt[4]  = '{1'b1, 4'd5, 32'hFFFF_FFFF, 32'h0};
        vt[5]  = '{1'b0, 4'd5, 32'h0,         32'h0000_0000};
        vt[6]  = '{1'b0, 4'd0, 32'h0,         32'h0000_000F};
        vt[7]  = '{1'b1, 4'd1, 32'hFFFF_FFFE, 32'h0};
        vt[8]  = '{1'b0, 4'd1, 32'h0,         32'h0000_0002};
        vt[9]  = '{1'b1, 4'd1, 32'h0000_0003, 32'h0};
        vt[10] = '{1'b0, 4'd1, 32'h0,         32'h0000_0003};
        vt[11] = '{1'b1, 4'd2, 32'h0000_00FF, 32'h0};
        vt[12] = '{1'b0, 4'd2, 32'h0,         32'h0000_0000};
        vt[13] = '{1'b1, 4'd0, 32'hFFFF_FFF5, 32'h0};
        vt[14] = '{1'b0, 4'd0, 32'h0,         32'h0000_0005};
        nv = 15;

        repeat (2) step();
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_rvalid", 32'(reg_rvalid), 32'd0);
        rst = 1'b0;
        step();

        chk("rst_activated", 32'(activated), 32'd1);
        chk("rst_nocontext", 32'(nocontext), 32'd1);
        chk("rst_notime", 32'(notime), 32'd1);
        chk("rst_delta", 32'(delta_address), 32'd1);
        chk("rst_encmode", 32'(encoder_mode), 32'd0);
        chk("rst_config", 32'(configuration), 32'(DELTA_ADDRESS));
        chk("gated_running", 32'(clk_gated), 32'd1);

        for (int i = 0; i < nv; i++) begin
            reg_op(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp, $sformatf("vec%0d", i));
        end
        chk("ctrl5_nocontext", 32'(nocontext), 32'd0);
        chk("ctrl5_notime", 32'(notime), 32'd1);
        chk("ctrl5_config", 32'(configuration), 32'(FULL_ADDRESS));
        reg_op(1'b1, 4'd0, 32'hF, 32'h0, "ctrl_restore");

        // Hardware on-edge, held level, off pulse, no retrigger.
        req_on = 2'b01;
        chk("on_pre_edge", 32'(enable), 32'd0);
        step();
        chk("on_edge", 32'(enable), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("on_held", 32'(enable), 32'd1);
        end
        req_off = 2'b01;
        step();
        req_off = 2'b00;
        chk("off_pulse", 32'(enable), 32'd0);
        step();
        chk("no_retrigger", 32'(enable), 32'd0);
        req_on = 2'b00;
        step();

        // Simultaneous on/off on channel 1: off wins.
        req_on  = 2'b10;
        req_off = 2'b10;
        step();
        chk("on_off_same", 32'(enable), 32'd0);
        req_on  = 2'b00;
        req_off = 2'b00;
        step();
        chk("on_off_after", 32'(enable), 32'd0);

        // CH_EN cleared while channel 1 is ON.
        req_on = 2'b10;
        step();
        req_on = 2'b00;
        chk("ch1_on", 32'(enable), 32'd2);
        reg_op(1'b1, 4'd1, 32'h1, 32'h0, "chen_write");
        chk("chen_lag", 32'(enable), 32'd2);
        step();
        chk("chen_drop", 32'(enable), 32'd0);
        reg_op(1'b1, 4'd1, 32'h3, 32'h0, "chen_restore");

        // Backpressure on channel 0.
        req_on = 2'b01;
        step();
        req_on = 2'b00;
        chk("stall_start_on", 32'(enable), 32'd1);
        ready = 1'b0;
`ifdef TRDB_REG_STALL_TIMEOUT_EN
        repeat (10) step();
        chk("stall10_enable", 32'(enable), 32'd1);
        ready = 1'b1;
        step();
        chk("stall10_resume", 32'(enable), 32'd1);
        reg_op(1'b0, 4'd2, 32'h0, 32'h0000_0001, "stall10_status");
        ready = 1'b0;
        repeat (15) step();
        chk("stall15_enable", 32'(enable), 32'd1);
        step();
        chk("stall16_drop", 32'(enable), 32'd0);
        ready = 1'b1;
        reg_op(1'b0, 4'd2, 32'h0, 32'h0000_0100, "stall16_status");
        reg_op(1'b1, 4'd2, 32'h0000_0100, 32'h0, "status_w1c");
        reg_op(1'b0, 4'd2, 32'h0, 32'h0000_0000, "status_cleared");
`else
        step();
        chk("legacy_drop", 32'(enable), 32'd0);
        ready = 1'b1;
        reg_op(1'b0, 4'd2, 32'h0, 32'h0000_0000, "legacy_status");
`endif

        // Software request pulses, then deactivate.
        reg_op(1'b1, 4'd3, 32'h0000_0003, 32'h0, "swreq_on");
        chk("swreq_both_on", 32'(enable), 32'd3);
        reg_op(1'b0, 4'd3, 32'h0, 32'h0, "swreq_read");
        reg_op(1'b1, 4'd0, 32'h0000_000E, 32'h0, "ctrl_deact");
        chk("deact_activated", 32'(activated), 32'd0);
        step();
        chk("deact_enable", 32'(enable), 32'd0);
        chk("deact_gated0", 32'(clk_gated), 32'd0);
        step();
        chk("deact_gated1", 32'(clk_gated), 32'd0);
        reg_op(1'b1, 4'd0, 32'h0000_000F, 32'h0, "ctrl_react");
        step();
        chk("react_gated", 32'(clk_gated), 32'd1);

        // Asynchronous reset while a channel is active/stalled.
        reg_op(1'b1, 4'd0, 32'h0000_0005, 32'h0, "pre_rst_ctrl");
        req_on = 2'b01;
        step();
        req_on = 2'b00;
        chk("pre_rst_on", 32'(enable), 32'd1);
`ifdef TRDB_REG_STALL_TIMEOUT_EN
        ready = 1'b0;
        repeat (5) step();
        chk("pre_rst_stall", 32'(enable), 32'd1);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_enable", 32'(enable), 32'd0);
        chk("async_rst_nocontext", 32'(nocontext), 32'd1);
        chk("async_rst_activated", 32'(activated), 32'd1);
        step();
        rst   = 1'b0;
        ready = 1'b1;
        step();
        reg_op(1'b0, 4'd0, 32'h0, 32'h0000_000F, "post_rst_ctrl");
        reg_op(1'b0, 4'd1, 32'h0, 32'h0000_0003, "post_rst_chen");
        reg_op(1'b0, 4'd2, 32'h0, 32'h0000_0000, "post_rst_status");
`ifdef TRDB_REG_STALL_TIMEOUT_EN
        req_on = 2'b01;
        step();
        req_on = 2'b00;
        ready  = 1'b0;
        repeat (15) step();
        chk("restart15_enable", 32'(enable), 32'd1);
        step();
        chk("restart16_drop", 32'(enable), 32'd0);
        ready = 1'b1;
        reg_op(1'b0, 4'd2, 32'h0, 32'h0000_0100, "restart_status");
`endif

        repeat (2) step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trdb_reg_mc.md
Name: trdb_reg_mc

Overview:
- Multi-channel successor of the trace-control register block.
- Holds encoder configuration in a small word-addressed register file.
- Runs one trace-enable state machine per channel, with tolerance for encapsulator backpressure.
- Sits between the trigger/filter units, the packet emitter and the encapsulator; channels map to harts/cores sharing one encoder back-end.

Parameters:
- NR_CHANNELS, 2, number of independent trace channels (1..8).
- ADDR_W, 4, register word-address width.
- STALL_TIMEOUT, 16, cycles `encapsulator_ready_i` may stay low before an ON channel is forced OFF (2..255).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- reg_req_i  in  1  register access strobe.
- reg_we_i  in  1  1=write, 0=read.
- reg_addr_i  in  ADDR_W  word address.
- reg_wdata_i  in  32  write data.
- reg_rdata_o  out  32  read data; valid when `reg_rvalid_o`=1.
- reg_rvalid_o  out  1  pulses one cycle after an accepted read.
- trace_req_on_i  in  NR_CHANNELS  per-channel turn-on request from the trigger unit (level).
- trace_req_off_i  in  NR_CHANNELS  per-channel turn-off request from the filter (level).
- encapsulator_ready_i  in  1  encapsulator can accept packets.
- trace_enable_o  out  NR_CHANNELS  per-channel tracing active.
- trace_activated_o  out  1  global activate (CTRL[0]).
- nocontext_o, notime_o, delta_address_o  out  1 each  CTRL[1], CTRL[2], CTRL[3].
- encoder_mode_o  out  1  constant 0.
- configuration_o  out  ioptions_e  DELTA_ADDRESS when CTRL[3]=1, otherwise the package's base/full option.
- clk_gated_o  out  1  `clk_i` gated by `trace_activated_o` (pulp_clock_gating, test_en=0).

Behaviour:
- Register map (word addresses):
  - 0 CTRL rw: [0] activated, [1] nocontext, [2] notime, [3] delta_address; reset 4'b1111.
  - 1 CH_EN rw: [NR_CHANNELS-1:0] channel allow mask; reset all 1.
  - 2 STATUS: [7:0] live `trace_enable_o` (ro); [15:8] sticky stall-drop flags (w1c).
  - 3 SW_REQ wo: writing 1 to bit c generates a one-cycle on-pulse for channel c (bits [7:0]); bits [15:8] do the same for off. Reads return 0.
  - Unmapped addresses read 0; writes to them are ignored.
- Register access:
  - Accepted every cycle.
  - A write takes effect on the next clock edge.
  - Read data is registered: `reg_rvalid_o`/`reg_rdata_o` appear the cycle after `reg_req_i`.
  - Unused read bits are 0.
- Request edge detection:
  - Each `trace_req_*_i` bit is registered (reset 0) and run through rising-edge detection: edge = d & ~q.
  - The on event is the hardware edge OR the SW_REQ on-pulse; the off event likewise.
- Per-channel FSM, states OFF / ON / STALL, reset OFF:
  - OFF -> ON: on event & CTRL[0] & CH_EN[c] & ~off event.
  - ON -> OFF: off event | ~CTRL[0] | ~CH_EN[c].
  - ON -> STALL: `encapsulator_ready_i`=0 (and no OFF condition).
  - STALL -> ON: ready=1 before timeout; counter cleared.
  - STALL -> OFF: counter reaches STALL_TIMEOUT-1, or any OFF condition. A timeout exit sets STATUS[8+c].
- Stall counter:
  - Per channel, $clog2(STALL_TIMEOUT) bits.
  - Counts only in STALL; saturates, never wraps; cleared on leaving STALL.
- `trace_enable_o[c]` = (state != OFF), registered.
- Timing: a request rising in cycle k is sampled at edge k and the FSM updates at that edge, so `trace_enable_o` is high in cycle k+1.
- Priorities:
  - Off beats on.
  - Timeout-drop and a STATUS w1c write in the same cycle: set wins.
- Reset mid-operation: all FSMs return to OFF, counters and flags clear, registers return to reset values; `trace_enable_o` is 0 immediately (asynchronous).

Optional Feature:
- Macro: TRDB_REG_STALL_TIMEOUT_EN.
- Defined: STALL state, stall counter and sticky flags exist as above.
- Undefined (legacy behaviour):
  - ON -> OFF as soon as `encapsulator_ready_i`=0.
  - No counter; STATUS[15:8] read 0.
  - STALL_TIMEOUT is unused.

Decomposition:
- trdb_pkg gains:
  - register address constants TRDB_REG_CTRL/CH_EN/STATUS/SW_REQ;
  - trdb_ch_state_e {CH_OFF, CH_ON, CH_STALL};
  - CTRL bit-index constants.
- ioptions_e is reused from trdb_pkg.
- Sub-module trdb_trace_ch_fsm: one channel's edge detectors, FSM and stall counter. Instantiated NR_CHANNELS times in a generate loop.

Test Plan:
- Reset, then read addr 0, 1, 2 -> 0x0000000F, 0x00000003, 0x00000000; `trace_enable_o`=2'b00.
- `trace_req_on_i`=2'b01 held high from cycle 5 -> `trace_enable_o`=2'b01 from cycle 6; no retrigger while held; pulse `trace_req_off_i[0]` -> 2'b00 next cycle.
- On and off edges for channel 1 in the same cycle -> channel stays OFF. Write CH_EN=2'b01 while channel 1 is ON -> channel 1 drops the following cycle.
- Channel 0 ON, ready low for 10 cycles (timeout 16) -> `trace_enable_o[0]` stays 1 and STATUS[8]=0. Ready low for 16 cycles -> `trace_enable_o[0]`=0 and STATUS[8]=1; write 0x100 to STATUS -> STATUS[8]=0. With the macro undefined, the first low cycle drops the channel.
- Write SW_REQ=0x0003 -> both channels ON next cycle. Write CTRL=0xE -> both OFF, `trace_activated_o`=0, `clk_gated_o` held low.
- Assert `rst_i` mid-STALL -> outputs and registers return to reset values asynchronously; the counter restarts from 0 after release.
